// File: rtl/tipi_rpi_pkg.sv
// +----------------------------------------------------------------------------+
// | tipi_rpi_pkg : register selects and link-state encodings for the RPi link  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package tipi_rpi_pkg;

  localparam logic [1:0] REGSEL_TD = 2'd0;
  localparam logic [1:0] REGSEL_TC = 2'd1;
  localparam logic [1:0] REGSEL_RD = 2'd2;
  localparam logic [1:0] REGSEL_RC = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FULL  = 2'd2
  } link_state_t;

endpackage

`default_nettype wire

// File: rtl/rpi_shift_regs_if.sv
// +----------------------------------------------------------------------------+
// | rpi_shift_regs_if : RPi serial pins plus TI-side latch/register signals    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface rpi_shift_regs_if #(
  parameter int WIDTH = 8
);

  logic             rpi_sclk;
  logic             rpi_sdata;
  logic             rpi_le;
  logic [1:0]       rpi_regsel;
  logic [WIDTH-1:0] td_in;
  logic [WIDTH-1:0] tc_in;
  logic             rpi_sout;
  logic [WIDTH-1:0] rd_q;
  logic [WIDTH-1:0] rc_q;
  logic             rd_stb;
  logic             rc_stb;
  logic             frame_err;

  // Drives the pins and latch values; the link block is the slave.
  modport master (
    output rpi_sclk, rpi_sdata, rpi_le, rpi_regsel, td_in, tc_in,
    input  rpi_sout, rd_q, rc_q, rd_stb, rc_stb, frame_err
  );

  modport slave (
    input  rpi_sclk, rpi_sdata, rpi_le, rpi_regsel, td_in, tc_in,
    output rpi_sout, rd_q, rc_q, rd_stb, rc_stb, frame_err
  );

endinterface

`default_nettype wire

// File: rtl/sync_edge.sv
// +----------------------------------------------------------------------------+
// | sync_edge : async input synchronizer with rising-edge detect; optional     |
// | 3-cycle glitch filter when RPI_GLITCH_FILTER_EN is defined.  Rev 1.0       |
// +----------------------------------------------------------------------------+
`default_nettype none

module sync_edge #(
  parameter int STAGES = 2
) (
  input  wire  clk,
  input  wire  rst,
  input  wire  din,
  output logic rise
);

  logic [STAGES-1:0] r_sync;
  logic              w_level;

  always_ff @(posedge clk) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[STAGES-2:0], din};
  end

  assign w_level = r_sync[STAGES-1];

`ifdef RPI_GLITCH_FILTER_EN
  logic [1:0] r_hist;
  logic       r_filt;

  // The filtered level only moves once three consecutive samples agree.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist <= '0;
      r_filt <= 1'b0;
    end else begin
      r_hist <= {r_hist[0], w_level};
      if (w_level == r_hist[0] && w_level == r_hist[1]) r_filt <= w_level;
    end
  end

  assign rise = w_level & r_hist[0] & r_hist[1] & ~r_filt;
`else
  logic r_prev;

  always_ff @(posedge clk) begin
    if (rst) r_prev <= 1'b0;
    else     r_prev <= w_level;
  end

  assign rise = w_level & ~r_prev;
`endif

endmodule

`default_nettype wire

// File: rtl/rpi_shift_regs.sv
// +----------------------------------------------------------------------------+
// | rpi_shift_regs : bit-serial TD/TC readback and RD/RC write link to the RPi |
// | Optional macro: RPI_GLITCH_FILTER_EN.  Rev 1.0                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module rpi_shift_regs
  import tipi_rpi_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input wire              clk,
  input wire              rst,
  rpi_shift_regs_if.slave bus
);

`ifdef RPI_GLITCH_FILTER_EN
  localparam int FILTER_LAT = 2;
`else
  localparam int FILTER_LAT = 0;
`endif
  // Data and regsel are delayed to line up with the filtered sclk/le events.
  localparam int SYNC_TOTAL = SYNC_STAGES + FILTER_LAT;
  localparam int CNT_W      = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(WIDTH);

  logic                  w_sclk_rise;
  logic                  w_le_rise;
  logic [SYNC_TOTAL-1:0] r_sdata_pipe;
  logic [1:0]            r_regsel_pipe [SYNC_TOTAL];
  logic                  w_sdata;
  logic [1:0]            w_regsel;

  logic [WIDTH-1:0]      r_shreg;
  logic [CNT_W-1:0]      r_bitcnt;
  logic [CNT_W-1:0]      w_cnt_inc;
  link_state_t           r_state;
  logic [WIDTH-1:0]      r_rd_q;
  logic [WIDTH-1:0]      r_rc_q;
  logic                  r_rd_stb;
  logic                  r_rc_stb;
  logic                  r_frame_err;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.rpi_sclk),
    .rise (w_sclk_rise)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_le_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.rpi_le),
    .rise (w_le_rise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sdata_pipe <= '0;
      for (int i = 0; i < SYNC_TOTAL; i++) r_regsel_pipe[i] <= 2'd0;
    end else begin
      r_sdata_pipe     <= {r_sdata_pipe[SYNC_TOTAL-2:0], bus.rpi_sdata};
      r_regsel_pipe[0] <= bus.rpi_regsel;
      for (int i = 1; i < SYNC_TOTAL; i++) r_regsel_pipe[i] <= r_regsel_pipe[i-1];
    end
  end

  assign w_sdata   = r_sdata_pipe[SYNC_TOTAL-1];
  assign w_regsel  = r_regsel_pipe[SYNC_TOTAL-1];
  assign w_cnt_inc = r_bitcnt + 1'b1;

  // le has priority: a coincident sclk edge is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg     <= '0;
      r_bitcnt    <= '0;
      r_state     <= ST_IDLE;
      r_rd_q      <= '0;
      r_rc_q      <= '0;
      r_rd_stb    <= 1'b0;
      r_rc_stb    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rd_stb    <= 1'b0;
      r_rc_stb    <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_le_rise) begin
        r_state  <= ST_IDLE;
        r_bitcnt <= '0;
        case (w_regsel)
          REGSEL_TD: r_shreg <= bus.td_in;
          REGSEL_TC: r_shreg <= bus.tc_in;
          REGSEL_RD: begin
            if (r_state == ST_FULL) begin
              r_rd_q   <= r_shreg;
              r_rd_stb <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end
          default: begin
            if (r_state == ST_FULL) begin
              r_rc_q   <= r_shreg;
              r_rc_stb <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end
        endcase
      end else if (w_sclk_rise) begin
        r_shreg <= {r_shreg[WIDTH-2:0], w_sdata};
        if (r_bitcnt != C_CNT_MAX) r_bitcnt <= w_cnt_inc;
        if (r_state != ST_FULL)
          r_state <= (w_cnt_inc == C_CNT_MAX) ? ST_FULL : ST_SHIFT;
      end
    end
  end

  assign bus.rpi_sout  = r_shreg[WIDTH-1];
  assign bus.rd_q      = r_rd_q;
  assign bus.rc_q      = r_rc_q;
  assign bus.rd_stb    = r_rd_stb;
  assign bus.rc_stb    = r_rc_stb;
  assign bus.frame_err = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_rpi_shift_regs.sv
// +----------------------------------------------------------------------------+
// | tb_rpi_shift_regs : directed self-checking bench for rpi_shift_regs        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_rpi_shift_regs;
  import tipi_rpi_pkg::*;

  localparam int WIDTH = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   n_rd_stb;
  int   n_rc_stb;
  int   n_ferr;

  rpi_shift_regs_if #(.WIDTH(WIDTH)) bus ();

  rpi_shift_regs #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (bus.rd_stb)    n_rd_stb++;
    if (bus.rc_stb)    n_rc_stb++;
    if (bus.frame_err) n_ferr++;
  end

  initial begin
    #(20 * 50000);
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sclk_bit(input logic b);
    bus.rpi_sdata = b;
    cycles(2);
    bus.rpi_sclk = 1'b1;
    cycles(6);
    bus.rpi_sclk = 1'b0;
    cycles(6);
  endtask

  task automatic shift_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) sclk_bit(v[i]);
  endtask

  task automatic le_pulse(input logic [1:0] sel);
    bus.rpi_regsel = sel;
    cycles(2);
    bus.rpi_le = 1'b1;
    cycles(6);
    bus.rpi_le = 1'b0;
    cycles(6);
  endtask

  initial begin
    int rd0, rc0, fe0;
    logic [7:0] pat;
    n_checks = 0; n_errors = 0;
    n_rd_stb = 0; n_rc_stb = 0; n_ferr = 0;
    rst = 1'b1;
    bus.rpi_sclk = 1'b0; bus.rpi_sdata = 1'b0; bus.rpi_le = 1'b0;
    bus.rpi_regsel = 2'd0; bus.td_in = 8'h00; bus.tc_in = 8'h00;
    cycles(4);
    check("rst_rd_q", 32'(bus.rd_q), 32'h0);
    check("rst_rc_q", 32'(bus.rc_q), 32'h0);
    check("rst_sout", 32'(bus.rpi_sout), 32'h0);
    check("rst_strobes", 32'({bus.rd_stb, bus.rc_stb, bus.frame_err}), 32'h0);
    check("rst_bitcnt", 32'(dut.r_bitcnt), 32'h0);
    check("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
    rst = 1'b0;
    cycles(4);
    check("post_rst_no_strobe", 32'(n_rd_stb + n_rc_stb + n_ferr), 32'h0);

    // Full RD write
    rd0 = n_rd_stb;
    shift_bits(16'h00A5, 8);
    check("t1_state_full", 32'(dut.r_state), 32'(ST_FULL));
    le_pulse(REGSEL_RD);
    check("t1_rd_q", 32'(bus.rd_q), 32'hA5);
    check("t1_rd_stb_once", 32'(n_rd_stb - rd0), 32'd1);
    check("t1_rc_q", 32'(bus.rc_q), 32'h0);

    // Full RC write, then a short RC frame must not disturb it
    rc0 = n_rc_stb;
    shift_bits(16'h005A, 8);
    le_pulse(REGSEL_RC);
    check("rc_write", 32'(bus.rc_q), 32'h5A);
    check("rc_stb_once", 32'(n_rc_stb - rc0), 32'd1);
    rc0 = n_rc_stb; fe0 = n_ferr;
    shift_bits(16'h001F, 5);
    le_pulse(REGSEL_RC);
    check("t2_frame_err_once", 32'(n_ferr - fe0), 32'd1);
    check("t2_rc_q_kept", 32'(bus.rc_q), 32'h5A);
    check("t2_no_rc_stb", 32'(n_rc_stb - rc0), 32'd0);
    check("t2_state_idle", 32'(dut.r_state), 32'(ST_IDLE));
    check("t2_rd_q_kept", 32'(bus.rd_q), 32'hA5);

    // TD readback, MSB first
    bus.td_in = 8'h3C;
    le_pulse(REGSEL_TD);
    bus.td_in = 8'hFF;
    pat = 8'h3C;
    check("t3_sout_b7", 32'(bus.rpi_sout), 32'(pat[7]));
    for (int i = 6; i >= 0; i--) begin
      sclk_bit(1'b0);
      check($sformatf("t3_sout_b%0d", i), 32'(bus.rpi_sout), 32'(pat[i]));
    end

    // TC readback
    bus.tc_in = 8'hC3;
    le_pulse(REGSEL_TC);
    check("tc_load", 32'(dut.r_shreg), 32'hC3);
    check("tc_sout", 32'(bus.rpi_sout), 32'h1);

    // Overlong frame keeps last 8 bits
    shift_bits(16'b11_0101_0110, 10);
    check("t4_bitcnt_sat", 32'(dut.r_bitcnt), 32'd8);
    le_pulse(REGSEL_RD);
    check("t4_rd_q", 32'(bus.rd_q), 32'h56);

    // Coincident sclk and le rises
    shift_bits(16'b101, 3);
    bus.td_in = 8'h81;
    bus.rpi_regsel = REGSEL_TD;
    bus.rpi_sdata = 1'b1;
    cycles(2);
    bus.rpi_sclk = 1'b1;
    bus.rpi_le = 1'b1;
    cycles(6);
    bus.rpi_sclk = 1'b0;
    bus.rpi_le = 1'b0;
    cycles(6);
    check("t5_shreg", 32'(dut.r_shreg), 32'h81);
    check("t5_bitcnt", 32'(dut.r_bitcnt), 32'h0);
    check("t5_state", 32'(dut.r_state), 32'(ST_IDLE));

    // Reset mid-frame
    shift_bits(16'h000F, 4);
    rd0 = n_rd_stb; rc0 = n_rc_stb; fe0 = n_ferr;
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(4);
    check("t6_no_strobe_rst", 32'((n_rd_stb - rd0) + (n_rc_stb - rc0) + (n_ferr - fe0)), 32'h0);
    check("t6_rd_q_cleared", 32'(bus.rd_q), 32'h0);
    check("t6_bitcnt", 32'(dut.r_bitcnt), 32'h0);
    shift_bits(16'h0081, 8);
    le_pulse(REGSEL_RD);
    check("t6_rd_q", 32'(bus.rd_q), 32'h81);
    check("t6_rd_stb_once", 32'(n_rd_stb - rd0), 32'd1);

`ifdef RPI_GLITCH_FILTER_EN
    // Two-cycle sclk glitch
    bus.rpi_sdata = 1'b1;
    cycles(2);
    bus.rpi_sclk = 1'b1;
    cycles(2);
    bus.rpi_sclk = 1'b0;
    cycles(8);
    check("glitch_shreg", 32'(dut.r_shreg), 32'h81);
    check("glitch_bitcnt", 32'(dut.r_bitcnt), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
